// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the async_fifo block.
package async_fifo_pkg;

    localparam int ASIZE_DEF       = 6;
    localparam int DSIZE_DEF       = 8;
    localparam int AFULL_SLACK_DEF = 4;

    // Helpers operate on a fixed 32-bit container; callers zero-extend
    // narrower pointers in and truncate the result back out.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing to the other side.
module ptr_sync #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_ptr,
    output logic [WIDTH-1:0] sync_ptr
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    // Capture the foreign pointer, then re-register it before use.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= async_ptr;
            sync_p1 <= sync_p0;
        end
    end

    assign sync_ptr = sync_p1;

endmodule

// File: rtl/async_fifo.sv
// First-word-fall-through FIFO with Gray-pointer flag logic, kept structured
// so the write and read sides can later be split onto separate clocks.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int ASIZE       = ASIZE_DEF,
    parameter int DSIZE       = DSIZE_DEF,
    parameter int AFULL_SLACK = AFULL_SLACK_DEF
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             wr_en_i,
    input  logic [DSIZE-1:0] wr_data_i,
    output logic             wr_full_o,
    output logic             wr_awfull_o,
    input  logic             rd_en_i,
    output logic [DSIZE-1:0] rd_data_o,
    output logic             rd_empty_o
);

    localparam int PTR_W = ASIZE + 1;
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [PTR_W-1:0] AFULL_LEVEL = PTR_W'(DEPTH - AFULL_SLACK);

    logic [DSIZE-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PTR_W-1:0] rbin, rgray, rbin_next, rgray_next;
    logic [PTR_W-1:0] wq2_gray, rq2_gray, rq2_bin;
    logic [PTR_W-1:0] full_match, wr_diff;
    logic             wr_fire, rd_fire;

    // Next-pointer and flag-compare arithmetic for both sides.
    always_comb begin
        wr_fire    = reset_n_i && wr_en_i && !wr_full_o;
        rd_fire    = reset_n_i && rd_en_i && !rd_empty_o;
        wbin_next  = wbin + PTR_W'(wr_fire);
        rbin_next  = rbin + PTR_W'(rd_fire);
        wgray_next = PTR_W'(bin2gray(32'(wbin_next)));
        rgray_next = PTR_W'(bin2gray(32'(rbin_next)));
        rq2_bin    = PTR_W'(gray2bin(32'(rq2_gray)));
        // Full when the write pointer has lapped the read pointer once:
        // in Gray code that means the top two bits differ, the rest match.
        full_match = {~rq2_gray[PTR_W-1:PTR_W-2], rq2_gray[PTR_W-3:0]};
        wr_diff    = wbin_next - rq2_bin;
    end

    // Write side: pointer plus registered full / almost-full flags.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wbin        <= '0;
            wgray       <= '0;
            wr_full_o   <= 1'b0;
            wr_awfull_o <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wgray       <= wgray_next;
            wr_full_o   <= (wgray_next == full_match);
            wr_awfull_o <= (wr_diff >= AFULL_LEVEL);
        end
    end

    // Storage array: no reset, written only on an accepted write.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wbin[ASIZE-1:0]] <= wr_data_i;
        end
    end

    // Read side: pointer plus registered empty flag.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rbin       <= '0;
            rgray      <= '0;
            rd_empty_o <= 1'b1;
        end else begin
            rbin       <= rbin_next;
            rgray      <= rgray_next;
            rd_empty_o <= (rgray_next == wq2_gray);
        end
    end

    assign rd_data_o = mem[rbin[ASIZE-1:0]];

    ptr_sync #(.WIDTH(PTR_W)) u_wptr_sync (
        .clk       (clk_i),
        .reset_n   (reset_n_i),
        .async_ptr (wgray),
        .sync_ptr  (wq2_gray)
    );

    ptr_sync #(.WIDTH(PTR_W)) u_rptr_sync (
        .clk       (clk_i),
        .reset_n   (reset_n_i),
        .async_ptr (rgray),
        .sync_ptr  (rq2_gray)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: directed flag-timing scenarios plus a
// randomized stream checked against a queue-based reference model.
module tb_async_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_full;
    logic       wr_awfull;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_empty;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model[$];

    async_fifo dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_data),
        .wr_full_o   (wr_full),
        .wr_awfull_o (wr_awfull),
        .rd_en_i     (rd_en),
        .rd_data_o   (rd_data),
        .rd_empty_o  (rd_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model.delete();
    endtask

    task automatic test_reset();
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'h11;
        reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_empty: got %b expected 1", rd_empty);
        end
        vectors++;
        if (wr_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_full: got %b expected 0", wr_full);
        end
        vectors++;
        if (wr_awfull !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_awfull: got %b expected 0", wr_awfull);
        end
        reset_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_leak: empty got %b expected 1", rd_empty);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();  // E0
        wr_en = 1'b0;
        for (int e = 0; e < 3; e++) begin
            vectors++;
            if (rd_empty !== 1'b1) begin
                miscompares++;
                $display("FAIL single_empty_E%0d: got %b expected 1", e, rd_empty);
            end
            tick();
        end
        vectors++;
        if (rd_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL single_empty_E3: got %b expected 0", rd_empty);
        end
        vectors++;
        if (rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_data: got %02h expected a5", rd_data);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL single_pop_empty: got %b expected 1", rd_empty);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            vectors++;
            if (wr_awfull !== (i + 1 >= 60)) begin
                miscompares++;
                $display("FAIL fill_awfull_%0d: got %b expected %b", i + 1, wr_awfull, (i + 1 >= 60));
            end
            vectors++;
            if (wr_full !== (i == 63)) begin
                miscompares++;
                $display("FAIL fill_full_%0d: got %b expected %b", i + 1, wr_full, (i == 63));
            end
        end
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        vectors++;
        if (wr_full !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_overflow_full: got %b expected 1", wr_full);
        end
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (rd_empty !== 1'b0 || rd_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL drain_%0d: got data %02h empty %b expected %02h empty 0", i, rd_data, rd_empty, 8'(i));
            end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        vectors++;
        if (rd_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_final_empty: got %b expected 1", rd_empty);
        end
    endtask

    task automatic test_release_full();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            d = 8'($urandom);
            model.push_back(d);
            wr_en = 1'b1;
            wr_data = d;
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        tick();
        rd_en = 1'b1;
        tick();  // E0: pop
        rd_en = 1'b0;
        void'(model.pop_front());
        for (int e = 0; e < 3; e++) begin
            vectors++;
            if (wr_full !== 1'b1) begin
                miscompares++;
                $display("FAIL release_full_E%0d: got %b expected 1", e, wr_full);
            end
            tick();
        end
        vectors++;
        if (wr_full !== 1'b0) begin
            miscompares++;
            $display("FAIL release_full_E3: got %b expected 0", wr_full);
        end
        wr_en = 1'b1;
        wr_data = 8'hC3;
        model.push_back(8'hC3);
        tick();
        wr_en = 1'b0;
        vectors++;
        if (wr_full !== 1'b1) begin
            miscompares++;
            $display("FAIL release_refill_full: got %b expected 1", wr_full);
        end
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (rd_empty !== 1'b0 || rd_data !== model[0]) begin
                miscompares++;
                $display("FAIL release_drain_%0d: got %02h empty %b expected %02h", i, rd_data, rd_empty, model[0]);
            end
            void'(model.pop_front());
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic test_stream_wrap();
        int wr_idx = 0;
        int rd_idx = 0;
        int cycles = 0;
        logic wr_acc, rd_acc;
        do_reset();
        while (rd_idx < 200 && cycles < 4000) begin
            wr_en = (wr_idx < 200) && ($urandom_range(3, 0) != 0);
            rd_en = ($urandom_range(1, 0) != 0);
            wr_data = 8'(wr_idx);
            if (model.size() == 64) begin
                vectors++;
                if (wr_full !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_full_flag: got %b expected 1 at 64 words", wr_full);
                end
            end
            if (!rd_empty) begin
                vectors++;
                if (model.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_underflow: empty got 0 expected 1 with 0 words");
                end else if (rd_data !== model[0]) begin
                    miscompares++;
                    $display("FAIL stream_data_%0d: got %02h expected %02h", rd_idx, rd_data, model[0]);
                end
            end
            wr_acc = wr_en && !wr_full;
            rd_acc = rd_en && !rd_empty;
            if (rd_acc && model.size() > 0) begin
                void'(model.pop_front());
                rd_idx++;
            end
            if (wr_acc) begin
                model.push_back(8'(wr_idx));
                wr_idx++;
            end
            tick();
            cycles++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        vectors++;
        if (rd_idx != 200) begin
            miscompares++;
            $display("FAIL stream_timeout: got %0d words read expected 200", rd_idx);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h30 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (rd_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_prefill_empty: got %b expected 0", rd_empty);
        end
        reset_n = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'hEE;
        tick();
        reset_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        vectors++;
        if (rd_empty !== 1'b1 || wr_full !== 1'b0 || wr_awfull !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_flags: got empty %b full %b awfull %b expected 1 0 0", rd_empty, wr_full, wr_awfull);
        end
        wr_en = 1'b1;
        wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (rd_empty !== 1'b0 || rd_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL mid_first_word: got %02h empty %b expected 5a empty 0", rd_data, rd_empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_release_full();
        test_stream_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 SHALL have parameter ASIZE, default 6, address width; depth = 2^ASIZE = 64.
REQ-002 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-003 SHALL have parameter AFULL_SLACK, default 4, free-slot margin for the almost-full flag.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port reset_n_i, input, 1 bit, synchronous active-low reset.
REQ-006 SHALL have port wr_en_i, input, 1 bit, write request.
REQ-007 SHALL have port wr_data_i, input, DSIZE bits, write data.
REQ-008 SHALL have port wr_full_o, output, 1 bit, FIFO full (write side).
REQ-009 SHALL have port wr_awfull_o, output, 1 bit, almost full (write side).
REQ-010 SHALL have port rd_en_i, input, 1 bit, pop request.
REQ-011 SHALL have port rd_data_o, output, DSIZE bits, head-of-FIFO word.
REQ-012 SHALL have port rd_empty_o, output, 1 bit, FIFO empty (read side).

Function
REQ-013 SHALL keep (ASIZE+1)-bit binary and Gray write and read pointers; the MSB is the wrap bit.
REQ-014 SHALL perform a write when wr_en_i=1 and wr_full_o=0: mem[wptr] <= wr_data_i and wptr increments at that edge.
REQ-015 SHALL ignore writes while wr_full_o=1, with no pointer or memory change.
REQ-016 SHALL be first-word-fall-through: rd_data_o = mem[rptr] combinationally, valid whenever rd_empty_o=0.
REQ-017 SHALL perform a pop when rd_en_i=1 and rd_empty_o=0, incrementing rptr at that edge; pops while empty are ignored.
REQ-018 SHALL pass each pointer to the opposite side in Gray code through a 2-flop synchronizer, which keeps the block retargetable to split clocks.
REQ-019 SHALL register rd_empty_o <= (next read Gray == synchronized write Gray); a write at edge E0 therefore clears empty at edge E3.
REQ-020 SHALL register wr_full_o <= (next write Gray == synchronized read Gray with its two MSBs inverted); full asserts at the edge of the filling write and deasserts at edge E3 after a pop at E0.
REQ-021 SHALL register wr_awfull_o <= ((next write binary - synchronized read binary) mod 2^(ASIZE+1)) >= 2^ASIZE - AFULL_SLACK, i.e. at 60 words for the defaults.
REQ-022 SHALL handle a simultaneous write and pop in the same cycle, both taking effect; pointer wrap past 2^ASIZE SHALL be seamless.
REQ-023 SHALL make empty pessimistic and full pessimistic: the flags never permit underflow or overflow, they may only lag.

Reset
REQ-024 SHALL, on reset_n_i=0 at a rising edge, clear both pointers and all synchronizer flops and set rd_empty_o=1, wr_full_o=0, wr_awfull_o=0.
REQ-025 SHALL not reset the memory array; rd_data_o is don't-care while rd_empty_o=1.
REQ-026 SHALL discard all stored words when reset is asserted mid-operation, and SHALL ignore wr_en_i/rd_en_i during reset.

Structure
REQ-027 SHALL take bin-to-Gray and Gray-to-bin functions and the default ASIZE/DSIZE constants from package async_fifo_pkg.
REQ-028 SHALL implement the 2-flop synchronizer as a single reusable sub-module ptr_sync (parameter WIDTH), instantiated twice.
REQ-029 SHALL infer the memory as a simple dual-port array (DSIZE x 2^ASIZE), written synchronously and read asynchronously.

Verification
REQ-030 SHALL cover reset: reset_n_i=0 for 2 cycles -> rd_empty_o=1, wr_full_o=0, wr_awfull_o=0.
REQ-031 SHALL cover a single write: write 0xA5 at E0 -> rd_empty_o=1 through E2, 0 after E3, rd_data_o=0xA5; one pop -> rd_empty_o=1 at the pop edge.
REQ-032 SHALL cover fill: 64 writes of 0x00..0x3F with no reads -> wr_awfull_o rises at the 60th write and wr_full_o at the 64th; a 65th write (0xFF) is dropped; draining yields 0x00..0x3F in order.
REQ-033 SHALL cover release from full: when full, one pop -> wr_full_o falls exactly 3 edges later, and a subsequent write is accepted.
REQ-034 SHALL cover streaming wrap: 200 bytes (n mod 256) with concurrent write/pop whenever flags allow -> the read sequence is identical, and no write is accepted while full and no pop while empty.
REQ-035 SHALL cover reset mid-operation: 10 words stored, then reset for 1 cycle -> rd_empty_o=1 next edge, and the next written word 0x5A is the first read out.
